// File: rtl/proto_stream_arbiter.sv
// Round-robin, message-granular arbiter that shares one protobuf deserializer
// among several byte streams, stripping each message's varint length prefix.
module proto_stream_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int MAX_LEN_BYTES = 2,
  parameter int SEL_W         = $clog2(NUM_SRC)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_SRC*8-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  output logic [NUM_SRC-1:0]   src_ready_o,
  output logic [7:0]           protoStream_o,
  output logic                 protoStream_valid_o,
  output logic [SEL_W-1:0]     src_sel_o,
  output logic                 msg_start_o,
  output logic                 msg_end_o,
  output logic                 len_err_o,
  output logic [NUM_SRC-1:0]   err_mask_o,
  output logic                 busy_o
);

  localparam int LEN_W = 7 * MAX_LEN_BYTES;
  localparam int IDX_W = (MAX_LEN_BYTES > 1) ? $clog2(MAX_LEN_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LEN, FWD} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_SRC-1:0] err_mask_q, err_mask_d;
  logic [LEN_W-1:0]   len_acc_q, len_acc_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   len_idx_q, len_idx_d;

  logic [7:0]         data_p1, data_d;
  logic               vld_p1, vld_d;
  logic               start_p1, start_d;
  logic               end_p1, end_d;
  logic               len_err_p1, len_err_d;

  logic [NUM_SRC-1:0] eligible;
  logic [SEL_W:0]     pick;
  logic [7:0]         cur_byte;
  logic               cur_valid;

  // First eligible source strictly after the last grant, wrapping modulo NUM_SRC.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_SRC-1:0] elig,
                                              input logic [SEL_W-1:0]   last);
    logic [SEL_W:0] res;
    int             idx;
    res = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_SRC;
      if (elig[idx]) res = {1'b1, SEL_W'(idx)};
    end
    return res;
  endfunction

  assign eligible  = src_valid_i & ~err_mask_q;
  assign pick      = rr_pick(eligible, last_q);
  assign cur_byte  = src_data_i[int'(sel_q)*8 +: 8];
  assign cur_valid = src_valid_i[sel_q];

  // Ready depends on registered state only, never on incoming valid.
  assign src_ready_o = (state_q != IDLE) ? (NUM_SRC'(1) << sel_q) : '0;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    err_mask_d = err_mask_q;
    len_acc_d  = len_acc_q;
    remain_d   = remain_q;
    len_d      = len_q;
    len_idx_d  = len_idx_q;
    data_d     = data_p1;
    vld_d      = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    len_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick[SEL_W]) begin
          sel_d     = pick[SEL_W-1:0];
          last_d    = pick[SEL_W-1:0];
          len_acc_d = '0;
          len_idx_d = '0;
          state_d   = LEN;
        end
      end
      LEN: begin
        if (cur_valid) begin
          len_acc_d[int'(len_idx_q)*7 +: 7] = cur_byte[6:0];
          if (!cur_byte[7]) begin
            if (len_acc_d == '0) begin
              state_d = IDLE;
            end else begin
              remain_d = len_acc_d;
              len_d    = len_acc_d;
              state_d  = FWD;
            end
          end else if (len_idx_q == IDX_W'(MAX_LEN_BYTES - 1)) begin
            len_err_d         = 1'b1;
            err_mask_d[sel_q] = 1'b1;
            state_d           = IDLE;
          end else begin
            len_idx_d = len_idx_q + IDX_W'(1);
          end
        end
      end
      FWD: begin
        if (cur_valid) begin
          data_d   = cur_byte;
          vld_d    = 1'b1;
          start_d  = (remain_q == len_q);
          end_d    = (remain_q == LEN_W'(1));
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: accepted byte and its framing pulses, one cycle after acceptance.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= SEL_W'(NUM_SRC - 1);
      err_mask_q <= '0;
      len_acc_q  <= '0;
      remain_q   <= '0;
      len_q      <= '0;
      len_idx_q  <= '0;
      data_p1    <= '0;
      vld_p1     <= 1'b0;
      start_p1   <= 1'b0;
      end_p1     <= 1'b0;
      len_err_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      err_mask_q <= err_mask_d;
      len_acc_q  <= len_acc_d;
      remain_q   <= remain_d;
      len_q      <= len_d;
      len_idx_q  <= len_idx_d;
      data_p1    <= data_d;
      vld_p1     <= vld_d;
      start_p1   <= start_d;
      end_p1     <= end_d;
      len_err_p1 <= len_err_d;
    end
  end

  assign protoStream_o       = data_p1;
  assign protoStream_valid_o = vld_p1;
  assign msg_start_o         = start_p1;
  assign msg_end_o           = end_p1;
  assign len_err_o           = len_err_p1;
  assign src_sel_o           = sel_q;
  assign err_mask_o          = err_mask_q;

endmodule

// File: tb/tb_proto_stream_arbiter.sv
// Directed bench for proto_stream_arbiter: per-source byte queues feed the DUT,
// outputs are sampled on the falling edge and compared with hand-derived values.
module tb_proto_stream_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] src_data_i;
  logic [3:0]  src_valid_i;
  logic [3:0]  src_ready_o;
  logic [7:0]  protoStream_o;
  logic        protoStream_valid_o;
  logic [1:0]  src_sel_o;
  logic        msg_start_o;
  logic        msg_end_o;
  logic        len_err_o;
  logic [3:0]  err_mask_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  proto_stream_arbiter #(.NUM_SRC(4), .MAX_LEN_BYTES(2)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .src_data_i          (src_data_i),
    .src_valid_i         (src_valid_i),
    .src_ready_o         (src_ready_o),
    .protoStream_o       (protoStream_o),
    .protoStream_valid_o (protoStream_valid_o),
    .src_sel_o           (src_sel_o),
    .msg_start_o         (msg_start_o),
    .msg_end_o           (msg_end_o),
    .len_err_o           (len_err_o),
    .err_mask_o          (err_mask_o),
    .busy_o              (busy_o)
  );

  int          checks = 0;
  int          errors = 0;

  logic [7:0]  mem [4][512];
  int          rd [4];
  int          wr [4];
  logic [3:0]  en;

  logic [7:0]  out_data  [1024];
  int          out_sel   [1024];
  logic        out_start [1024];
  logic        out_end   [1024];
  int          gr        [64];
  int          n_out, n_gr, n_start, n_end, n_lenerr;
  logic        prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ow();
    return {19'd0, protoStream_valid_o, msg_start_o, msg_end_o, src_sel_o, protoStream_o};
  endfunction

  function automatic logic [31:0] ew(input logic v, input logic s, input logic e,
                                     input logic [1:0] sel, input logic [7:0] d);
    return {19'd0, v, s, e, sel, d};
  endfunction

  task automatic push(input int s, input logic [7:0] b);
    mem[s][wr[s]] = b;
    wr[s]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
  endtask

  task automatic clear_log();
    n_out = 0; n_gr = 0; n_start = 0; n_end = 0; n_lenerr = 0;
    prev_busy = 1'b0;
  endtask

  // One clock: drive at the falling edge, handshake at the rising edge, sample after.
  task automatic cycle();
    logic [3:0] rdy;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && rd[i] != wr[i]) begin
        src_valid_i[i]       = 1'b1;
        src_data_i[8*i +: 8] = mem[i][rd[i]];
      end else begin
        src_valid_i[i]       = 1'b0;
        src_data_i[8*i +: 8] = 8'h00;
      end
    end
    #1;
    rdy = src_ready_o;
    @(posedge clk_i);
    for (int i = 0; i < 4; i++)
      if (src_valid_i[i] && rdy[i]) rd[i]++;
    @(negedge clk_i);
    if (protoStream_valid_o && n_out < 1024) begin
      out_data[n_out]  = protoStream_o;
      out_sel[n_out]   = int'(src_sel_o);
      out_start[n_out] = msg_start_o;
      out_end[n_out]   = msg_end_o;
      n_out++;
    end
    if (msg_start_o) n_start++;
    if (msg_end_o)   n_end++;
    if (len_err_o)   n_lenerr++;
    if (busy_o && !prev_busy && n_gr < 64) begin
      gr[n_gr] = int'(src_sel_o);
      n_gr++;
    end
    prev_busy = busy_o;
  endtask

  task automatic reset_dut();
    reset_i = 1'b1;
    clear_q();
    cycle();
    cycle();
    reset_i = 1'b0;
    clear_log();
  endtask

  initial begin
    int budget;
    int bad;
    int msgno, s, m, j;

    reset_i     = 1'b1;
    src_valid_i = '0;
    src_data_i  = '0;
    en          = '1;
    clear_q();
    clear_log();
    @(negedge clk_i);
    cycle();
    cycle();

    // Reset state
    chk("rst_out",   ow(), 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {28'd0, src_ready_o}, 32'd0);
    chk("rst_mask",  {28'd0, err_mask_o}, 32'd0);
    chk("rst_lerr",  {31'd0, len_err_o}, 32'd0);

    // Single message on source 0: prefix 0x03, body 08 96 01
    reset_i = 1'b0;
    clear_log();
    push(0, 8'h03); push(0, 8'h08); push(0, 8'h96); push(0, 8'h01);
    cycle();
    chk("t1_grant_busy", {31'd0, busy_o}, 32'd1);
    chk("t1_ready",      {28'd0, src_ready_o}, 32'h1);
    cycle();
    chk("t1_len_cycle",  ow(), ew(0, 0, 0, 2'd0, 8'h00));
    cycle();
    chk("t1_byte0",      ow(), ew(1, 1, 0, 2'd0, 8'h08));
    cycle();
    chk("t1_byte1",      ow(), ew(1, 0, 0, 2'd0, 8'h96));
    cycle();
    chk("t1_byte2",      ow(), ew(1, 0, 1, 2'd0, 8'h01));
    chk("t1_idle",       {31'd0, busy_o}, 32'd0);

    // Four sources always valid, two 2-byte messages each
    reset_dut();
    for (int si = 0; si < 4; si++)
      for (int mi = 0; mi < 2; mi++) begin
        push(si, 8'h02);
        push(si, {4'(si + 1), 4'(2 * mi)});
        push(si, {4'(si + 1), 4'(2 * mi + 1)});
      end
    repeat (20) cycle();
    chk("t2_ngrant", n_gr, 5);
    chk("t2_nout",   n_out, 10);
    for (int g = 0; g < 5; g++) chk("t2_grant_order", gr[g], g % 4);
    for (int k = 0; k < 10; k++) begin
      msgno = k / 2; s = msgno % 4; m = msgno / 4; j = k % 2;
      chk("t2_sel",   out_sel[k], s);
      chk("t2_data",  {24'd0, out_data[k]}, {24'd0, 4'(s + 1), 4'(2 * m + j)});
      chk("t2_flags", {30'd0, out_start[k], out_end[k]}, {30'd0, j == 0, j == 1});
    end

    // Two-byte prefix (length 129) with random stalls
    reset_dut();
    push(0, 8'h81); push(0, 8'h01);
    for (int k = 0; k < 129; k++) push(0, 8'(k));
    budget = 0;
    while (n_out < 129 && budget < 2000) begin
      en[0] = 1'($urandom_range(0, 1));
      cycle();
      budget++;
    end
    en = '1;
    repeat (4) cycle();
    chk("t3_count",  n_out, 129);
    bad = 0;
    for (int k = 0; k < n_out; k++)
      if (out_data[k] !== 8'(k) || out_sel[k] != 0) bad++;
    chk("t3_data_mismatches", bad, 0);
    chk("t3_nstart",   n_start, 1);
    chk("t3_nend",     n_end, 1);
    chk("t3_end_last", {31'd0, out_end[128]}, 32'd1);
    chk("t3_start_first", {31'd0, out_start[0]}, 32'd1);
    chk("t3_consumed", rd[0], wr[0]);

    // Empty message on source 2, then source 3
    reset_dut();
    push(2, 8'h00);
    push(3, 8'h01); push(3, 8'h55);
    cycle();
    cycle();
    chk("t4_empty_idle", {31'd0, busy_o}, 32'd0);
    chk("t4_empty_out",  ow(), ew(0, 0, 0, 2'd2, 8'h00));
    repeat (6) cycle();
    chk("t4_ngrant", n_gr, 2);
    chk("t4_grant0", gr[0], 2);
    chk("t4_grant1", gr[1], 3);
    chk("t4_nout",   n_out, 1);
    chk("t4_byte",   ew(1, out_start[0], out_end[0], 2'(out_sel[0]), out_data[0]),
                     ew(1, 1, 1, 2'd3, 8'h55));
    chk("t4_nstart", n_start, 1);

    // Overlong prefix on source 1; its valid stays high afterwards
    reset_dut();
    push(1, 8'h80); push(1, 8'h80);
    for (int k = 0; k < 8; k++) push(1, 8'h05);
    cycle();
    cycle();
    chk("t5_no_err_yet", {31'd0, len_err_o}, 32'd0);
    cycle();
    chk("t5_len_err",  {31'd0, len_err_o}, 32'd1);
    chk("t5_mask",     {28'd0, err_mask_o}, 32'h2);
    cycle();
    chk("t5_err_pulse_once", {31'd0, len_err_o}, 32'd0);
    chk("t5_masked_idle",    {31'd0, busy_o}, 32'd0);
    push(0, 8'h01); push(0, 8'hAA);
    push(2, 8'h01); push(2, 8'hBB);
    repeat (8) cycle();
    chk("t5_ngrant",  n_gr, 3);
    chk("t5_grant0",  gr[0], 1);
    chk("t5_grant1",  gr[1], 2);
    chk("t5_grant2",  gr[2], 0);
    chk("t5_nlenerr", n_lenerr, 1);
    chk("t5_mask_sticky", {28'd0, err_mask_o}, 32'h2);
    chk("t5_src1_untouched", rd[1], 2);
    chk("t5_src1_valid", {31'd0, src_valid_i[1]}, 32'd1);
    chk("t5_nout",    n_out, 2);
    chk("t5_out0",    {22'd0, 2'(out_sel[0]), out_data[0]}, {22'd0, 2'd2, 8'hBB});
    chk("t5_out1",    {22'd0, 2'(out_sel[1]), out_data[1]}, {22'd0, 2'd0, 8'hAA});

    // Reset on the second body byte of a 5-byte message from source 3
    reset_dut();
    push(3, 8'h05);
    for (int k = 1; k <= 5; k++) push(3, 8'h30 + 8'(k));
    repeat (3) cycle();
    chk("t6_byte0",  ow(), ew(1, 1, 0, 2'd3, 8'h31));
    reset_i = 1'b1;
    cycle();
    chk("t6_rst_out",   ow(), 32'd0);
    chk("t6_rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("t6_rst_ready", {28'd0, src_ready_o}, 32'd0);
    chk("t6_no_end",    n_end, 0);
    reset_i = 1'b0;
    clear_log();
    push(0, 8'h01); push(0, 8'hC0);
    cycle();
    chk("t6_regrant_sel",  {30'd0, src_sel_o}, 32'd0);
    chk("t6_regrant_busy", {31'd0, busy_o}, 32'd1);
    cycle();
    cycle();
    chk("t6_src0_byte", ow(), ew(1, 1, 1, 2'd0, 8'hC0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
